// File: rtl/rs_queue_pkg.sv
// Shared types for the reservation station: ROB tag/instruction widths, the operand
// record and the CDB capture helper.
package rs_queue_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ROB_WIDTH  = 6;
  localparam int OPND_W     = 32;

  // Same layout as the CDB broadcast record
  typedef struct packed {
    logic                 rdy;
    logic [ROB_WIDTH-1:0] tag;
    logic [OPND_W-1:0]    data;
  } operand_t;

  function automatic operand_t snoop(input operand_t op, input logic cdb_valid,
                                     input logic [ROB_WIDTH-1:0] cdb_tag,
                                     input logic [OPND_W-1:0] cdb_data);
    operand_t r;
    r = op;
    if (cdb_valid && !op.rdy && (op.tag == cdb_tag)) begin
      r.rdy  = 1'b1;
      r.data = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_queue_entry.sv
// One reservation-station slot: holds an instruction and its operands, captures CDB
// results, and can load a new entry or take the state of the next-younger slot.
module rs_entry
  import rs_queue_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          i_shift,
  input  logic                          i_load,
  input  logic                          i_nxt_valid,
  input  logic [INST_WIDTH-1:0]         i_nxt_inst,
  input  logic [ROB_WIDTH-1:0]          i_nxt_tag,
  input  operand_t [NUM_SRC-1:0]        i_nxt_src,
  input  logic [INST_WIDTH-1:0]         i_new_inst,
  input  logic [ROB_WIDTH-1:0]          i_new_tag,
  input  operand_t [NUM_SRC-1:0]        i_new_src,
  input  logic                          i_cdb_valid,
  input  logic [ROB_WIDTH-1:0]          i_cdb_tag,
  input  logic [OPND_W-1:0]             i_cdb_data,
  output logic                          o_valid,
  output logic [INST_WIDTH-1:0]         o_inst,
  output logic [ROB_WIDTH-1:0]          o_tag,
  output operand_t [NUM_SRC-1:0]        o_src,
  output logic                          o_eligible
);

  logic                   r_valid;
  logic [INST_WIDTH-1:0]  r_inst;
  logic [ROB_WIDTH-1:0]   r_tag;
  operand_t [NUM_SRC-1:0] r_src;

  logic                   w_valid_nx;
  logic [INST_WIDTH-1:0]  w_inst_nx;
  logic [ROB_WIDTH-1:0]   w_tag_nx;
  operand_t [NUM_SRC-1:0] w_src_nx;
  logic                   w_all_rdy;

  // A load always wins over a shift; the snoop applies to whichever source is taken
  always_comb begin
    w_valid_nx = i_shift ? i_nxt_valid : r_valid;
    w_inst_nx  = i_shift ? i_nxt_inst  : r_inst;
    w_tag_nx   = i_shift ? i_nxt_tag   : r_tag;
    for (int k = 0; k < NUM_SRC; k++)
      w_src_nx[k] = snoop(i_shift ? i_nxt_src[k] : r_src[k], i_cdb_valid, i_cdb_tag, i_cdb_data);
    if (i_load) begin
      w_valid_nx = 1'b1;
      w_inst_nx  = i_new_inst;
      w_tag_nx   = i_new_tag;
      for (int k = 0; k < NUM_SRC; k++)
        w_src_nx[k] = snoop(i_new_src[k], i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
  end

  always_comb begin
    w_all_rdy = 1'b1;
    for (int k = 0; k < NUM_SRC; k++)
      if (!r_src[k].rdy) w_all_rdy = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_tag   <= '0;
      r_src   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_nx;
      r_inst  <= w_inst_nx;
      r_tag   <= w_tag_nx;
      r_src   <= w_src_nx;
    end
  end

  assign o_valid    = r_valid;
  assign o_inst     = r_inst;
  assign o_tag      = r_tag;
  assign o_src      = r_src;
  assign o_eligible = r_valid && w_all_rdy;

endmodule

// File: rtl/rs_queue.sv
// Age-ordered reservation station with CDB snoop. Define RS_OOO_EN to dispatch the
// oldest eligible entry from any slot; otherwise only slot 0 dispatches (in order).
module rs_queue
  import rs_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = ROB_WIDTH,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int SW     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INST_WIDTH-1:0]          in_inst,
  input  logic [TAG_W-1:0]               in_tag,
  input  operand_t [NUM_SRC-1:0]         in_src,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INST_WIDTH-1:0]          out_inst,
  output logic [TAG_W-1:0]               out_tag,
  output logic [NUM_SRC-1:0][DATA_W-1:0] out_data,
  output logic [CW-1:0]                  count
);

  logic [CW-1:0]          r_count;

  // Index DEPTH is an always-empty slot feeding the top slot's shift-in path
  logic [DEPTH:0]         w_valid;
  logic [INST_WIDTH-1:0]  w_inst [DEPTH+1];
  logic [ROB_WIDTH-1:0]   w_tag  [DEPTH+1];
  operand_t [NUM_SRC-1:0] w_src  [DEPTH+1];
  logic [DEPTH-1:0]       w_elig;
  logic [DEPTH-1:0]       w_shift;
  logic [DEPTH-1:0]       w_load;
  logic [SW-1:0]          w_sel;
  logic                   w_found;
  logic                   w_remove;
  logic                   w_ins;
  logic [CW-1:0]          w_ins_pos;
  logic                   w_unused_elig;

  assign w_valid[DEPTH] = 1'b0;
  assign w_inst[DEPTH]  = '0;
  assign w_tag[DEPTH]   = '0;
  assign w_src[DEPTH]   = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_entry #(.NUM_SRC(NUM_SRC)) u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .i_shift     (w_shift[i]),
      .i_load      (w_load[i]),
      .i_nxt_valid (w_valid[i+1]),
      .i_nxt_inst  (w_inst[i+1]),
      .i_nxt_tag   (w_tag[i+1]),
      .i_nxt_src   (w_src[i+1]),
      .i_new_inst  (in_inst),
      .i_new_tag   (ROB_WIDTH'(in_tag)),
      .i_new_src   (in_src),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (ROB_WIDTH'(cdb_tag)),
      .i_cdb_data  (OPND_W'(cdb_data)),
      .o_valid     (w_valid[i]),
      .o_inst      (w_inst[i]),
      .o_tag       (w_tag[i]),
      .o_src       (w_src[i]),
      .o_eligible  (w_elig[i])
    );
  end

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
`ifdef RS_OOO_EN
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel   = SW'(i);
        w_found = 1'b1;
      end
    end
`else
    w_found = w_elig[0];
`endif
  end

  assign w_unused_elig = ^w_elig;

  assign in_ready  = (r_count < CW'(DEPTH)) && !flush;
  assign w_ins     = in_valid && in_ready;
  assign w_remove  = w_found && out_ready;
  assign w_ins_pos = w_remove ? r_count - CW'(1) : r_count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_shift[i] = w_remove && (SW'(i) >= w_sel);
      w_load[i]  = w_ins && (w_ins_pos == CW'(i));
    end
  end

  always_comb begin
    out_valid = w_found;
    out_inst  = w_inst[w_sel];
    out_tag   = TAG_W'(w_tag[w_sel]);
    for (int k = 0; k < NUM_SRC; k++)
      out_data[k] = DATA_W'(w_src[w_sel][k].data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_count <= '0;
    else if (flush) r_count <= '0;
    else            r_count <= r_count + CW'(w_ins) - CW'(w_remove);
  end

  assign count = r_count;

endmodule

// File: tb/tb_rs_queue.sv
// Self-checking bench for rs_queue: directed steps then random traffic, compared
// each cycle against an array-based model of the reservation station.
module tb_rs_queue;
  import rs_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int NS    = 2;

  logic                   clk = 1'b0;
  logic                   reset, flush, in_valid, in_ready;
  logic [INST_WIDTH-1:0]  in_inst;
  logic [ROB_WIDTH-1:0]   in_tag;
  operand_t [NS-1:0]      in_src;
  logic                   cdb_valid;
  logic [ROB_WIDTH-1:0]   cdb_tag;
  logic [31:0]            cdb_data;
  logic                   out_valid, out_ready;
  logic [INST_WIDTH-1:0]  out_inst;
  logic [ROB_WIDTH-1:0]   out_tag;
  logic [NS-1:0][31:0]    out_data;
  logic [2:0]             count;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: entries kept oldest-first
  int          m_n;
  logic [31:0] m_inst [DEPTH];
  logic [5:0]  m_tag  [DEPTH];
  logic        m_rdy  [DEPTH][NS];
  logic [5:0]  m_st   [DEPTH][NS];
  logic [31:0] m_d    [DEPTH][NS];

  rs_queue #(.DEPTH(DEPTH), .NUM_SRC(NS), .DATA_W(32), .TAG_W(ROB_WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .in_src(in_src), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_tag(out_tag), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int j);
    for (int k = 0; k < NS; k++) if (!m_rdy[j][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_sel();
`ifdef RS_OOO_EN
    for (int j = 0; j < m_n; j++) if (m_ready(j)) return j;
`else
    if (m_n > 0 && m_ready(0)) return 0;
`endif
    return -1;
  endfunction

  task automatic put(input bit v, input logic [5:0] tg,
                     input bit r0, input logic [5:0] t0, input logic [31:0] d0,
                     input bit r1, input logic [5:0] t1, input logic [31:0] d1);
    in_valid = v; in_tag = tg; in_inst = $urandom;
    in_src[0].rdy = r0; in_src[0].tag = t0; in_src[0].data = d0;
    in_src[1].rdy = r1; in_src[1].tag = t1; in_src[1].data = d1;
  endtask

  task automatic cdb(input bit v, input logic [5:0] t, input logic [31:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cycle();
    int  s;
    bit  ins, rem;
    #1;
    s = m_sel();
    chk("count", 64'(count), 64'(m_n));
    chk("in_ready", 64'(in_ready), 64'(m_n < DEPTH && !flush));
    chk("out_valid", 64'(out_valid), 64'(s >= 0));
    if (s >= 0) begin
      chk("out_tag", 64'(out_tag), 64'(m_tag[s]));
      chk("out_inst", 64'(out_inst), 64'(m_inst[s]));
      chk("out_data0", 64'(out_data[0]), 64'(m_d[s][0]));
      chk("out_data1", 64'(out_data[1]), 64'(m_d[s][1]));
    end
    ins = in_valid && (m_n < DEPTH) && !flush;
    rem = (s >= 0) && out_ready;
    @(posedge clk);
    if (flush) m_n = 0;
    else begin
      for (int j = 0; j < m_n; j++)
        for (int k = 0; k < NS; k++)
          if (cdb_valid && !m_rdy[j][k] && m_st[j][k] == cdb_tag) begin
            m_rdy[j][k] = 1'b1; m_d[j][k] = cdb_data;
          end
      if (rem) begin
        for (int j = s; j < m_n - 1; j++) begin
          m_inst[j] = m_inst[j+1]; m_tag[j] = m_tag[j+1];
          for (int k = 0; k < NS; k++) begin
            m_rdy[j][k] = m_rdy[j+1][k]; m_st[j][k] = m_st[j+1][k]; m_d[j][k] = m_d[j+1][k];
          end
        end
        m_n--;
      end
      if (ins) begin
        m_inst[m_n] = in_inst; m_tag[m_n] = in_tag;
        for (int k = 0; k < NS; k++) begin
          m_rdy[m_n][k] = in_src[k].rdy; m_st[m_n][k] = in_src[k].tag; m_d[m_n][k] = in_src[k].data;
          if (cdb_valid && !in_src[k].rdy && in_src[k].tag == cdb_tag) begin
            m_rdy[m_n][k] = 1'b1; m_d[m_n][k] = cdb_data;
          end
        end
        m_n++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; m_n = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    cdb(0, 0, 0);
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // both operands ready
    put(1, 3, 1, 0, 5, 1, 0, 7); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0); out_ready = 1'b1; cycle(); cycle();

    // wakeup from CDB
    put(1, 1, 0, 9, 0, 1, 0, 32'h55); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    cdb(1, 9, 32'h1234); cycle();
    cdb(0, 0, 0); cycle(); cycle();

    // fill, reject fifth, single dispatch
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1, 6'(10 + i), 1, 0, 32'(100 + i), 1, 0, 32'(200 + i)); cycle();
    end
    chk("full_count", 64'(count), 64'd4);
    put(0, 0, 0, 0, 0, 0, 0, 0); out_ready = 1'b1; cycle();
    out_ready = 1'b0; cycle();
    chk("after_pop_count", 64'(count), 64'd3);
    out_ready = 1'b1; repeat (4) cycle();

    // insert bypass
    out_ready = 1'b0;
    put(1, 20, 0, 6, 0, 1, 0, 99); cdb(1, 6, 32'hABCD); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0); cdb(0, 0, 0); cycle();
    out_ready = 1'b1; cycle(); cycle();

    // blocked head with ready younger entry
    put(1, 30, 0, 2, 0, 1, 0, 1); cycle();
    put(1, 31, 1, 0, 3, 1, 0, 4); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    cdb(1, 2, 77); cycle();
    cdb(0, 0, 0); repeat (4) cycle();

    // flush beats a simultaneous insert
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1, 6'(40 + i), 1, 0, 32'(i), 1, 0, 32'(i)); cycle();
    end
    put(1, 50, 1, 0, 1, 1, 0, 2); flush = 1'b1; cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0); flush = 1'b0; cycle();
    chk("flush_count", 64'(count), 64'd0);

    // asynchronous reset mid-operation
    put(1, 60, 1, 0, 1, 1, 0, 1); cycle(); cycle();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    m_n = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      put($urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)),
          $urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)), $urandom);
      cdb($urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), $urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 49) == 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
